firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench
===========================================================

Name: firebird7_in_gate1_tessent_data_mux_ctrl

Overview:
Sequences ownership of a W-bit functional/IJTAG data mux so that switching between functional and IJTAG data is always safe.
- Quiesces the functional side before asserting the mux select.
- Holds a shadow register that drives the mux's IJTAG data input.
- Inserts guard cycles on every switch in both directions.
- Sits in the gate1 IJTAG instrument, one instance per mux.

Parameters:
WIDTH, 3, data width of the controlled mux
GUARD_CYCLES, 2, settle cycles between handshake and select change (0 allowed)
TIMEOUT_CYCLES, 1024, cycles in IJTAG state without a load before forced release (optional feature only)

Ports:
ijtag_tck  input  1  clock
ijtag_reset  input  1  reset, synchronous, active-high
ijtag_sel_req  input  1  level request for IJTAG ownership of the mux
func_quiet  input  1  functional side idle acknowledge, level
functional_data_in  input  WIDTH  live functional value; seeds the shadow on takeover
ijtag_load  input  1  one-cycle pulse: load shadow from ijtag_load_data
ijtag_load_data  input  WIDTH  new IJTAG value
func_hold_req  output  1  asks functional side to quiesce
ijtag_select  output  1  drives mux select
ijtag_data_out  output  WIDTH  shadow register; drives mux IJTAG data input
ijtag_grant  output  1  IJTAG owns mux and loads are accepted
timeout_flag  output  1  sticky forced-release indicator

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state FUNC, all 1-bit outputs 0, ijtag_data_out all zeros, guard counter 0.
- States and outputs:
  - FUNC: hold=0, select=0, grant=0.
  - HOLD: hold=1, waiting for func_quiet.
  - SETTLE_IN: hold=1, counting GUARD_CYCLES.
  - IJTAG: hold=1, select=1, grant=1.
  - SETTLE_OUT: hold=1, select=0, counting GUARD_CYCLES.
- FUNC -> HOLD when sel_req=1. func_hold_req goes high the cycle after sel_req is sampled.
- HOLD -> SETTLE_IN when func_quiet=1. On this transition the shadow is loaded with functional_data_in, so the value on the mux output does not change at the select edge.
- HOLD -> FUNC when sel_req drops before quiet is seen. Hold deasserts; no select pulse occurs.
- SETTLE_IN: counter runs 0..GUARD_CYCLES-1, then -> IJTAG.
  - GUARD_CYCLES=0: IJTAG is entered on the next cycle.
  - sel_req dropping here -> FUNC directly; select was never asserted.
- IJTAG:
  - ijtag_load=1 -> shadow updated the following cycle.
  - Loads in any other state are ignored.
  - sel_req=0 -> SETTLE_OUT; select and grant fall on entry.
- SETTLE_OUT: counts GUARD_CYCLES, then -> FUNC, and func_hold_req falls.
  - sel_req re-asserting here is ignored until FUNC is reached; no shortcut back to IJTAG.
- The shadow retains its last value after release.
- func_quiet falling while in SETTLE_IN or IJTAG is ignored. The protocol requires it to stay high while hold=1, and the bench checks that with an assertion only.
- Reset mid-operation returns to FUNC on the next edge: select=0, hold=0, shadow zeroed.
- Counter width is $clog2(GUARD_CYCLES+1), with a minimum of 1.

Optional Feature:
FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
- Defined:
  - An idle counter runs in IJTAG and clears on each accepted load.
  - On reaching TIMEOUT_CYCLES-1 it forces IJTAG -> SETTLE_OUT regardless of sel_req and sets timeout_flag.
  - timeout_flag is sticky and cleared only by reset.
  - After the release completes, FUNC re-enters HOLD only after sel_req has been seen low for at least one cycle.
- Undefined: no idle counter, and timeout_flag is tied 0.

Decomposition:
- Package firebird7_in_gate1_data_mux_ctrl_pkg holds:
  - the state enum typedef (5 states, 3-bit);
  - the default GUARD_CYCLES and TIMEOUT_CYCLES localparams.
- One natural sub-module, firebird7_in_gate1_data_mux_ctrl_guard_cnt: a loadable down-counter with a done flag, shared by SETTLE_IN and SETTLE_OUT.
- The existing data mux is instantiated beside this block, not inside it.

Test Plan:
- Reset, then sel_req=1, func_quiet=1 from the next cycle, GUARD_CYCLES=2, functional_data_in=3'b101 -> hold at +1, select/grant at +4, ijtag_data_out=3'b101 at the select edge (no glitch).
- In IJTAG, ijtag_load pulse with data 3'b010 -> ijtag_data_out=3'b010 one cycle later; a load pulse in FUNC -> no change.
- sel_req drops in IJTAG -> select/grant fall next cycle, hold falls 3 cycles later (GUARD_CYCLES=2), shadow stays 3'b010.
- sel_req pulses high 2 cycles with func_quiet=0 -> hold pulses, select never asserts, return to FUNC.
- ijtag_reset asserted during SETTLE_IN and during IJTAG -> next edge: all outputs 0, shadow 0.
- With FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8: hold IJTAG with no loads -> forced release after 8 cycles, timeout_flag=1 sticky; no re-entry until sel_req toggles low then high.

Source files
------------

// File: rtl/firebird7_in_gate1_data_mux_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_data_mux_ctrl_pkg
//
// Shared definitions for the gate1 functional/IJTAG data mux controller:
//   - mux_state_e    : ownership FSM state encoding (5 states, 3 bits)
//   - DEF_GUARD_CYCLES / DEF_TIMEOUT_CYCLES : parameter defaults
//   - cnt_width()    : width of a counter that must hold 0..max_val (min 1)
// -----------------------------------------------------------------------------
package firebird7_in_gate1_data_mux_ctrl_pkg;

    localparam int DEF_GUARD_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_FUNC       = 3'd0,  // functional side owns the mux
        ST_HOLD       = 3'd1,  // functional side asked to quiesce
        ST_SETTLE_IN  = 3'd2,  // guard cycles before select rises
        ST_IJTAG      = 3'd3,  // IJTAG owns the mux, loads accepted
        ST_SETTLE_OUT = 3'd4   // guard cycles before hold is released
    } mux_state_e;

    // $clog2 returns 0 for max_val == 0; a counter still needs one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : firebird7_in_gate1_data_mux_ctrl_pkg

// File: rtl/firebird7_in_gate1_data_mux_ctrl_guard_cnt.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_data_mux_ctrl_guard_cnt
//
// Loadable down-counter with a done flag, shared by the SETTLE_IN and
// SETTLE_OUT guard intervals. Load wins over decrement; the count saturates
// at zero so a held decrement never wraps.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (count -> 0)
//   load_i      load load_val_i this cycle
//   load_val_i  start value (guard length minus one)
//   dec_i       decrement while nonzero
//   done_o      count is zero
// -----------------------------------------------------------------------------
module firebird7_in_gate1_data_mux_ctrl_guard_cnt #(
    parameter int CNT_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule : firebird7_in_gate1_data_mux_ctrl_guard_cnt

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_data_mux_ctrl
//
// Sequences ownership of a WIDTH-bit functional/IJTAG data mux. The functional
// side is quiesced before select rises, guard cycles separate the handshake
// from every select change, and a shadow register drives the mux IJTAG data
// input. The shadow is seeded from the live functional value on takeover so
// the mux output does not move at the select edge.
//
// Optional feature (macro FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN):
//   an idle counter in IJTAG forces a release after TIMEOUT_CYCLES cycles
//   without a load, sets a sticky timeout_flag, and blocks re-entry until
//   ijtag_sel_req has been seen low. Without the macro timeout_flag is 0.
//
// Ports:
//   ijtag_tck           clock
//   ijtag_reset         synchronous active-high reset
//   ijtag_sel_req       level request for IJTAG ownership
//   func_quiet          functional side idle acknowledge
//   functional_data_in  live functional value, seeds the shadow on takeover
//   ijtag_load          one-cycle pulse: load shadow (accepted in IJTAG only)
//   ijtag_load_data     new IJTAG value
//   func_hold_req       asks functional side to quiesce
//   ijtag_select        mux select
//   ijtag_data_out      shadow register, mux IJTAG data input
//   ijtag_grant         IJTAG owns the mux and loads are accepted
//   timeout_flag        sticky forced-release indicator
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_data_mux_ctrl
    import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel_req,
    input  logic             func_quiet,
    input  logic [WIDTH-1:0] functional_data_in,
    input  logic             ijtag_load,
    input  logic [WIDTH-1:0] ijtag_load_data,
    output logic             func_hold_req,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_grant,
    output logic             timeout_flag
);

    if (GUARD_CYCLES < 0) begin : g_bad_guard
        $error("GUARD_CYCLES must be >= 0");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    localparam int               CNT_W      = cnt_width(GUARD_CYCLES);
    // Guard of 0 or 1 both leave the settle state after one cycle.
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

    mux_state_e       state_q;
    mux_state_e       state_d;
    logic             hold_q;
    logic             select_q;
    logic             grant_q;
    logic [WIDTH-1:0] shadow_q;

    logic             guard_load;
    logic             guard_dec;
    logic             guard_done;
    logic             timeout_hit;
    logic             reentry_block;

    // ------------------------------------------------------------------------
    // Guard interval counter
    // ------------------------------------------------------------------------
    assign guard_dec = (state_q == ST_SETTLE_IN) || (state_q == ST_SETTLE_OUT);

    firebird7_in_gate1_data_mux_ctrl_guard_cnt #(
        .CNT_W (CNT_W)
    ) u_guard_cnt (
        .clk_i      (ijtag_tck),
        .rst_i      (ijtag_reset),
        .load_i     (guard_load),
        .load_val_i (GUARD_LOAD),
        .dec_i      (guard_dec),
        .done_o     (guard_done)
    );

    // ------------------------------------------------------------------------
    // Ownership FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        guard_load = 1'b0;
        case (state_q)
            ST_FUNC: begin
                if (ijtag_sel_req && !reentry_block) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A withdrawn request wins over a late quiet acknowledge.
                if (!ijtag_sel_req) begin
                    state_d = ST_FUNC;
                end else if (func_quiet) begin
                    state_d    = ST_SETTLE_IN;
                    guard_load = 1'b1;
                end
            end
            ST_SETTLE_IN: begin
                // Select has not risen yet, so a drop can go straight home.
                if (!ijtag_sel_req) begin
                    state_d = ST_FUNC;
                end else if (guard_done) begin
                    state_d = ST_IJTAG;
                end
            end
            ST_IJTAG: begin
                if (!ijtag_sel_req || timeout_hit) begin
                    state_d    = ST_SETTLE_OUT;
                    guard_load = 1'b1;
                end
            end
            ST_SETTLE_OUT: begin
                // Requests are ignored here; the release always completes.
                if (guard_done) begin
                    state_d = ST_FUNC;
                end
            end
            default: begin
                state_d = ST_FUNC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, registered outputs and shadow register
    // ------------------------------------------------------------------------
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_q  <= ST_FUNC;
            hold_q   <= 1'b0;
            select_q <= 1'b0;
            grant_q  <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state they describe.
            hold_q   <= (state_d != ST_FUNC);
            select_q <= (state_d == ST_IJTAG);
            grant_q  <= (state_d == ST_IJTAG);
            if ((state_q == ST_HOLD) && (state_d == ST_SETTLE_IN)) begin
                shadow_q <= functional_data_in;
            end else if ((state_q == ST_IJTAG) && ijtag_load) begin
                shadow_q <= ijtag_load_data;
            end
        end
    end

    assign func_hold_req  = hold_q;
    assign ijtag_select   = select_q;
    assign ijtag_grant    = grant_q;
    assign ijtag_data_out = shadow_q;

    // ------------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------------
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
    localparam int               IDLE_W    = cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q;
    logic              timeout_q;
    logic              rearm_q;   // set on forced release until sel_req seen low

    assign timeout_hit   = (state_q == ST_IJTAG) && !ijtag_load && (idle_q == IDLE_LAST);
    assign reentry_block = rearm_q;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
            rearm_q   <= 1'b0;
        end else begin
            if ((state_q != ST_IJTAG) || ijtag_load) begin
                idle_q <= '0;
            end else if (!timeout_hit) begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (timeout_hit) begin
                rearm_q <= 1'b1;
            end else if (!ijtag_sel_req) begin
                rearm_q <= 1'b0;
            end
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign reentry_block = 1'b0;
    assign timeout_flag  = 1'b0;
`endif

endmodule : firebird7_in_gate1_tessent_data_mux_ctrl

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_firebird7_in_gate1_tessent_data_mux_ctrl
//
// Each step drives one cycle of inputs and pushes the hand-derived output
// vector expected after the next rising edge; the scenario task pops it one
// time unit after that edge and compares.
// Observed vector layout: {hold, select, grant, timeout_flag, data[2:0]}.
// Timeout scenario runs only with FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    localparam int WIDTH = 3;

    typedef struct {
        logic             rst;
        logic             sel;
        logic             quiet;
        logic             load;
        logic [WIDTH-1:0] ldata;
        logic [WIDTH-1:0] fdata;
        logic [6:0]       exp;
    } step_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             sel_req;
    logic             quiet;
    logic [WIDTH-1:0] fdata;
    logic             load;
    logic [WIDTH-1:0] ldata;
    logic             hold;
    logic             select;
    logic [WIDTH-1:0] data_out;
    logic             grant;
    logic             tflag;

    logic [6:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;

    wire [6:0] obs = {hold, select, grant, tflag, data_out};

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH          (WIDTH),
        .GUARD_CYCLES   (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst),
        .ijtag_sel_req      (sel_req),
        .func_quiet         (quiet),
        .functional_data_in (fdata),
        .ijtag_load         (load),
        .ijtag_load_data    (ldata),
        .func_hold_req      (hold),
        .ijtag_select       (select),
        .ijtag_data_out     (data_out),
        .ijtag_grant        (grant),
        .timeout_flag       (tflag)
    );

    // Protocol: once quiet has been acknowledged under hold, it must stay high
    // until hold is released.
    logic quiet_seen = 1'b0;
    always @(negedge clk) begin
        if (rst || !hold) begin
            quiet_seen <= 1'b0;
        end else begin
            assert (!quiet_seen || quiet)
                else $error("protocol: func_quiet dropped while functional side held");
            if (quiet) quiet_seen <= 1'b1;
        end
    end

    function automatic step_t mk(input logic r, input logic s, input logic q, input logic l,
                                 input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] fd,
                                 input logic [6:0] e);
        step_t st;
        st.rst = r; st.sel = s; st.quiet = q; st.load = l;
        st.ldata = ld; st.fdata = fd; st.exp = e;
        return st;
    endfunction

    // Drive one cycle of stimulus and record what must appear after the edge.
    task automatic apply(input step_t st);
        rst     = st.rst;
        sel_req = st.sel;
        quiet   = st.quiet;
        load    = st.load;
        ldata   = st.ldata;
        fdata   = st.fdata;
        sb_q.push_back(st.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(1, 1, 1, 1, 3'b111, 3'b111, 7'b000_0_000));
        s.push_back(mk(1, 1, 1, 1, 3'b111, 3'b111, 7'b000_0_000));
        s.push_back(mk(0, 0, 0, 0, 3'b000, 3'b000, 7'b000_0_000));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_takeover();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(0, 1, 0, 0, 3'b000, 3'b101, 7'b100_0_000)); // HOLD
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b101, 7'b100_0_101)); // SETTLE_IN, seed
        s.push_back(mk(0, 1, 1, 1, 3'b111, 3'b011, 7'b100_0_101)); // load ignored
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b111_0_101)); // IJTAG, no glitch
        s.push_back(mk(0, 1, 1, 1, 3'b010, 3'b011, 7'b111_0_010)); // load accepted
        s.push_back(mk(0, 1, 1, 0, 3'b111, 3'b011, 7'b111_0_010)); // no pulse
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL takeover[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_release();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b011, 7'b100_0_010)); // SETTLE_OUT
        s.push_back(mk(0, 1, 1, 1, 3'b111, 3'b011, 7'b100_0_010)); // no shortcut, load ignored
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b011, 7'b000_0_010)); // FUNC, hold falls
        s.push_back(mk(0, 0, 1, 1, 3'b111, 3'b011, 7'b000_0_010)); // load in FUNC ignored
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL release[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_abort();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 7'b100_0_010)); // HOLD, no quiet
        s.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 7'b100_0_010));
        s.push_back(mk(0, 0, 0, 0, 3'b000, 3'b110, 7'b000_0_010)); // back to FUNC
        s.push_back(mk(0, 0, 0, 0, 3'b000, 3'b110, 7'b000_0_010));
        s.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 7'b100_0_010)); // HOLD
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b110, 7'b100_0_110)); // SETTLE_IN
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b110, 7'b000_0_110)); // drop -> FUNC
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b110, 7'b000_0_110));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL abort[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b100_0_110)); // HOLD
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b100_0_011)); // SETTLE_IN
        s.push_back(mk(1, 1, 1, 0, 3'b000, 3'b011, 7'b000_0_000)); // reset in SETTLE_IN
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b100_0_000)); // HOLD
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b100_0_011));
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b100_0_011));
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 7'b111_0_011)); // IJTAG
        s.push_back(mk(1, 1, 1, 0, 3'b000, 3'b011, 7'b000_0_000)); // reset in IJTAG
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b011, 7'b000_0_000));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask

`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        step_t s[$];
        logic [6:0] e;
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_0_000)); // HOLD
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_0_100)); // SETTLE_IN
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_0_100));
        for (int k = 0; k < 8; k++) begin
            s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b111_0_100)); // 8 idle IJTAG cycles
        end
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_1_100)); // forced SETTLE_OUT
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_1_100));
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b000_1_100)); // FUNC
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b000_1_100)); // re-entry blocked
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b000_1_100));
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b100, 7'b000_1_100)); // seen low
        s.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 7'b100_1_100)); // HOLD again
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b100, 7'b000_1_100));
        s.push_back(mk(1, 0, 1, 0, 3'b000, 3'b100, 7'b000_0_000)); // reset clears flag
        s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b100, 7'b000_0_000));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL timeout[%0d]: got {hold,sel,grant,tflag,data}=%b required %b", i, obs, e);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; sel_req = 1'b0; quiet = 1'b0; load = 1'b0;
        ldata = '0; fdata = '0;
        test_reset();
        test_takeover();
        test_release();
        test_abort();
        test_reset_mid();
`ifdef FIREBIRD7_DATA_MUX_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_firebird7_in_gate1_tessent_data_mux_ctrl
